// File: rtl/cms_axis_trace_receiver.sv
// AXI-Stream trace sink: buffers 512-bit beats in a FIFO and replays each as eight 64-bit words.
// Optional packet-length checker enabled by defining CMS_RX_TLAST_CHECK_EN.
module cms_axis_trace_receiver #(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_WIDTH-1:0]     out_data,
    output logic [2:0]                out_word_idx,
    output logic                      out_last,
    output logic [31:0]               beat_count,
    output logic [31:0]               pkt_count,
    output logic                      tlast_err
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ENT_W    = AXI_DATA_WIDTH + 1;
    localparam logic [2:0]  LAST_IDX = 3'((AXI_DATA_WIDTH / WORD_WIDTH) - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ENT_W-1:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          w_count_nxt;
    logic                      r_tready;
    logic [AXI_DATA_WIDTH-1:0] r_beat;
    logic                      r_tlast;
    logic [2:0]                r_word_idx;
    logic [2:0]                w_idx_inc;
    logic                      r_valid;
    logic                      r_out_last;
    logic [31:0]               r_beat_count;
    logic [31:0]               r_pkt_count;
    logic [ENT_W-1:0]          w_head;
    logic                      w_accept;
    logic                      w_take;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_load;
    logic                      w_advance;

    // Clear blocks the handshake combinationally so a beat is never acknowledged and then flushed.
    assign S_AXIS_tready = r_tready && !clear;
    assign out_valid     = r_valid;
    assign out_data      = r_beat[WORD_WIDTH-1:0];
    assign out_word_idx  = r_word_idx;
    assign out_last      = r_out_last;
    assign beat_count    = r_beat_count;
    assign pkt_count     = r_pkt_count;

    assign w_accept  = S_AXIS_tvalid && S_AXIS_tready;
    assign w_take    = r_valid && out_ready;
    assign w_empty   = (r_count == '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_idx_inc = r_word_idx + 3'd1;

    // Serializer next-state: load on idle, or reload without a bubble after word 7 is taken.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_take) begin
                    if (r_word_idx == LAST_IDX) begin
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {S_AXIS_tlast, S_AXIS_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_tready     <= 1'b0;
            r_beat       <= '0;
            r_tlast      <= 1'b0;
            r_word_idx   <= '0;
            r_valid      <= 1'b0;
            r_out_last   <= 1'b0;
            r_beat_count <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
                r_beat_count <= r_beat_count + 32'd1;
                if (S_AXIS_tlast) begin
                    r_pkt_count <= r_pkt_count + 32'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count  <= w_count_nxt;
            r_tready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
            r_valid  <= (w_state_nxt == S_SHIFT);
            if (w_load) begin
                r_beat     <= w_head[AXI_DATA_WIDTH-1:0];
                r_tlast    <= w_head[ENT_W-1];
                r_word_idx <= '0;
                r_out_last <= 1'b0;
            end else if (w_advance) begin
                r_beat     <= r_beat >> WORD_WIDTH;
                r_word_idx <= w_idx_inc;
                r_out_last <= (w_idx_inc == LAST_IDX) && r_tlast;
            end else if (w_take) begin
                r_word_idx <= '0;
                r_out_last <= 1'b0;
            end
        end
    end

`ifdef CMS_RX_TLAST_CHECK_EN
    logic [31:0] r_pkt_beats;
    logic [31:0] w_pkt_beats_inc;
    logic        r_tlast_err;
    logic        w_chk_en;

    assign w_pkt_beats_inc = r_pkt_beats + 32'd1;
    assign w_chk_en        = (tlast_interval != 32'd0);
    assign tlast_err       = r_tlast_err;

    // Beats-in-packet counter includes the current beat when compared against the interval.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_pkt_beats <= '0;
            r_tlast_err <= 1'b0;
        end else if (w_accept) begin
            if (S_AXIS_tlast) begin
                r_pkt_beats <= '0;
                if (w_chk_en && (w_pkt_beats_inc != tlast_interval)) begin
                    r_tlast_err <= 1'b1;
                end
            end else if (w_chk_en && (w_pkt_beats_inc == tlast_interval)) begin
                r_pkt_beats <= '0;
                r_tlast_err <= 1'b1;
            end else begin
                r_pkt_beats <= w_pkt_beats_inc;
            end
        end
    end
`else
    logic w_unused_interval;

    assign w_unused_interval = ^tlast_interval;
    assign tlast_err         = 1'b0;
`endif

endmodule
